alu_secuenciador: RTL and testbench

Command-driven sequencer wrapped around the combinational ALU. It holds the two operand registers, accepts load/execute commands over a valid/ready handshake, and drives the ALU's operand, `flagin` and `select` inputs. It captures the ALU result and flags into an output register, presented on a second valid/ready handshake. It sits between the board-level input logic (switches/buttons FSM) and the display path, so the ALU itself stays purely combinational.

---
 rtl/alu_secuenciador.sv | 154 +++++++++++++++
 tb/tb_alu_secuenciador.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_secuenciador.sv
// alu_secuenciador: command-driven sequencer around the combinational ALU.
// Holds operands RA/RB, takes LOAD_A / LOAD_B / EXEC / EXEC_ACC commands,
// drives the ALU inputs and captures result + flags into an output register.
// Optional feature macro: ALU_SEQ_STICKY_EN (sticky flag accumulator).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and its payload until that edge; ready never
// depends combinationally on valid. cmd_ready=1 only in IDLE, res_valid=1
// only in DONE, and res_data/res_flags/res_err are stable while res_valid=1.
module alu_secuenciador #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_code,
  input  logic [N-1:0] cmd_data,
  input  logic [3:0]   cmd_sel,
  input  logic         cmd_flagin,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_flagin,
  output logic [3:0]   alu_select,
  input  logic [N-1:0] alu_resultado,
  input  logic         alu_negativo,
  input  logic         alu_zero,
  input  logic         alu_cout,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [3:0]   res_flags,
  output logic         res_err,
  output logic [3:0]   sticky_flags,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SEL_NOP = 4'd10;

  state_t         state, state_n;
  logic [N-1:0]   ra, rb;
  logic [3:0]     sel_r;
  logic           fin_r;
  logic           acc_r;
  logic           cmd_accept;
  logic           sel_ok;

  assign cmd_accept = cmd_valid && (state == IDLE);
  assign sel_ok     = (cmd_sel <= 4'd9);
  assign alu_a      = ra;
  assign alu_b      = rb;
  assign alu_flagin = fin_r;
  assign dbg_state  = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake / select outputs.
  always_comb begin
    state_n    = state;
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    alu_select = SEL_NOP;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_code[1]) state_n = sel_ok ? EXEC : DONE;
      end
      EXEC: begin
        alu_select = sel_r;
        state_n    = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand, command-field and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra        <= '0;
      rb        <= '0;
      sel_r     <= SEL_NOP;
      fin_r     <= 1'b0;
      acc_r     <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            case (cmd_code)
              2'b00: ra <= cmd_data;
              2'b01: rb <= cmd_data;
              default: begin
                if (sel_ok) begin
                  sel_r <= cmd_sel;
                  fin_r <= cmd_flagin;
                  acc_r <= cmd_code[0];
                end else begin
                  // Reserved select: no ALU cycle, report an error result.
                  res_data  <= '0;
                  res_flags <= '0;
                  res_err   <= 1'b1;
                end
              end
            endcase
          end
        end
        EXEC: begin
          res_data  <= alu_resultado;
          res_flags <= {alu_negativo, alu_zero, alu_cout, alu_overflow};
          res_err   <= 1'b0;
          if (acc_r) ra <= alu_resultado;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  logic [3:0] sticky_r;

  // Sticky flags: OR of every captured ALU flag set since reset or LOAD_A.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_r <= '0;
    end else if (cmd_accept && (cmd_code == 2'b00)) begin
      sticky_r <= '0;
    end else if (state == EXEC) begin
      sticky_r <= sticky_r | {alu_negativo, alu_zero, alu_cout, alu_overflow};
    end
  end

  assign sticky_flags = sticky_r;
`else
  assign sticky_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_secuenciador.sv
// Testbench for alu_secuenciador: a behavioural ALU stand-in closes the loop,
// directed steps exercise load/exec/accumulate/reserved/backpressure/reset,
// and a scoreboard queue holds expected {data, flags, err} per EXEC command.
module tb_alu_secuenciador;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_code;
  logic [N-1:0] cmd_data;
  logic [3:0]   cmd_sel;
  logic         cmd_flagin;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_flagin;
  logic [3:0]   alu_select;
  logic [N-1:0] alu_resultado;
  logic         alu_negativo, alu_zero, alu_cout, alu_overflow;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic [3:0]   res_flags;
  logic         res_err;
  logic [3:0]   sticky_flags;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [N+4:0] exp_q[$];
  logic [N-1:0] m_ra = '0;
  logic [N-1:0] m_rb = '0;
  logic [3:0]   m_sticky = '0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU stand-in: returns {result, neg, zero, cout, ovf} ----------------
  function automatic logic [N+3:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [3:0] sel, input logic fin);
    logic [N:0]   w;
    logic [N-1:0] r;
    logic         c, v;
    w = '0; c = 1'b0; v = 1'b0;
    case (sel)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[N-1:0]; c = w[N];
              v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[N-1:0]; c = w[N];
              v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
      4'd2: begin w = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, fin}; r = w[N-1:0]; c = w[N];
              v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      4'd3: begin w = {1'b0, a} + 1; r = w[N-1:0]; c = w[N]; end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~a;
      4'd8: begin r = {a[N-2:0], fin}; c = a[N-1]; end
      4'd9: begin r = {fin, a[N-1:1]}; c = a[0]; end
      default: return '0;
    endcase
    return {r, r[N-1], (r == '0), c, v};
  endfunction

  assign {alu_resultado, alu_negativo, alu_zero, alu_cout, alu_overflow} =
    alu_f(alu_a, alu_b, alu_select, alu_flagin);

  alu_secuenciador #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_flagin(cmd_flagin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_flagin(alu_flagin), .alu_select(alu_select),
    .alu_resultado(alu_resultado), .alu_negativo(alu_negativo), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_err(res_err), .sticky_flags(sticky_flags),
    .dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sticky(input string tag);
`ifdef ALU_SEQ_STICKY_EN
    chk(tag, sticky_flags, m_sticky);
`else
    chk(tag, sticky_flags, 4'b0000);
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] code, input logic [N-1:0] data,
                      input logic [3:0] sel, input logic fin);
    logic [N+3:0] a;
    @(negedge clk);
    cmd_code = code; cmd_data = data; cmd_sel = sel; cmd_flagin = fin;
    cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    case (code)
      2'b00: begin m_ra = data; m_sticky = '0; end
      2'b01: m_rb = data;
      default: begin
        if (sel <= 4'd9) begin
          a = alu_f(m_ra, m_rb, sel, fin);
          exp_q.push_back({a, 1'b0});
          m_sticky = m_sticky | a[3:0];
          if (code[0]) m_ra = a[N+3:4];
        end else begin
          exp_q.push_back({{(N+4){1'b0}}, 1'b1});
        end
      end
    endcase
  endtask

  // Called at a negedge while in DONE; pops and compares one result.
  task automatic check_result(output logic [N+4:0] e);
    chk("exp_q_nonempty", (exp_q.size() != 0), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("res_data", res_data, e[N+4:5]);
    chk("res_flags", res_flags, e[4:1]);
    chk("res_err", res_err, e[0]);
    chk_sticky("sticky_flags");
  endtask

  task automatic release_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);
    chk("res_valid_after_release", res_valid, 0);
  endtask

  task automatic run_exec(input logic [1:0] code, input logic [3:0] sel, input logic fin);
    logic [N+4:0] e;
    int n;
    send(code, '0, sel, fin);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_within_bound", res_valid, 1);
    check_result(e);
    release_result();
    chk("alu_a_tracks_ra", alu_a, m_ra);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [N+4:0] e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_data = '0;
    cmd_sel = '0; cmd_flagin = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_select", alu_select, 4'd10);
    chk("rst_alu_flagin", alu_flagin, 0);
    chk("rst_state", dbg_state, 2'd0);
    chk_sticky("rst_sticky");

    // LOAD_A 3, LOAD_B 5 back to back, then EXEC sum: 3+5 wraps to 0.
    send(2'b00, 3'd3, 4'd0, 1'b0);
    send(2'b01, 3'd5, 4'd0, 1'b0);
    @(negedge clk);
    chk("load_alu_a", alu_a, 3);
    chk("load_alu_b", alu_b, 5);
    send(2'b10, '0, 4'd0, 1'b1);
    @(negedge clk);
    chk("exec_cycle_res_valid", res_valid, 0);
    chk("exec_cycle_cmd_ready", cmd_ready, 0);
    chk("exec_cycle_alu_select", alu_select, 4'd0);
    chk("exec_cycle_alu_flagin", alu_flagin, 1);
    @(negedge clk);
    chk("exec_latency_res_valid", res_valid, 1);
    chk("done_alu_select_nop", alu_select, 4'd10);
    check_result(e);
    chk("sum_res_data_const", res_data, 0);
    chk("sum_res_flags_const", res_flags, 4'b0110);
    release_result();

    // Accumulate: 6 & 3 = 2 into RA, then 2 | 3 = 3 into RA.
    send(2'b00, 3'd6, 4'd0, 1'b0);
    send(2'b01, 3'd3, 4'd0, 1'b0);
    run_exec(2'b11, 4'd4, 1'b0);
    chk("acc_and_ra", alu_a, 2);
    run_exec(2'b11, 4'd5, 1'b0);
    chk("acc_or_ra", alu_a, 3);

    // Reserved select: DONE after one edge with error result, RA unchanged.
    send(2'b11, '0, 4'd12, 1'b0);
    @(negedge clk);
    chk("reserved_latency_res_valid", res_valid, 1);
    check_result(e);
    chk("reserved_res_err_const", res_err, 1);
    chk("reserved_ra_unchanged", alu_a, 3);
    release_result();

    // Backpressure: hold result for 5 cycles while cmd_valid pulses.
    send(2'b10, '0, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_result(e);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_code = 2'b00; cmd_data = 3'd7;
      @(posedge clk);
      @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_res_data", res_data, e[N+4:5]);
      chk("bp_res_flags", res_flags, e[4:1]);
      chk("bp_ra_unchanged", alu_a, m_ra);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_cmd_ready", cmd_ready, 1);
    chk("bp_ra_after", alu_a, m_ra);

    // Sticky sequence: sum with carry, then AND with no flags, then LOAD_A.
    send(2'b00, 3'd3, 4'd0, 1'b0);
    send(2'b01, 3'd5, 4'd0, 1'b0);
    run_exec(2'b10, 4'd0, 1'b0);
    run_exec(2'b10, 4'd4, 1'b0);
    @(negedge clk);
    chk_sticky("sticky_persist");
`ifdef ALU_SEQ_STICKY_EN
    chk("sticky_cout_bit", sticky_flags[1], 1);
`endif
    send(2'b00, 3'd1, 4'd0, 1'b0);
    @(negedge clk);
    chk_sticky("sticky_after_load_a");

    // Randomized loads and executes, including reserved selects.
    for (int i = 0; i < 10; i++) begin
      send(2'b00, 3'($urandom_range(0, 7)), 4'd0, 1'b0);
      send(2'b01, 3'($urandom_range(0, 7)), 4'd0, 1'b0);
      run_exec(2'($urandom_range(2, 3)), 4'($urandom_range(0, 11)),
               1'($urandom_range(0, 1)));
    end

    // Reset in the EXEC cycle discards the pending result.
    send(2'b00, 3'd5, 4'd0, 1'b0);
    send(2'b01, 3'd2, 4'd0, 1'b0);
    send(2'b11, '0, 4'd0, 1'b0);
    @(negedge clk);
    chk("pre_reset_in_exec", dbg_state, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(exp_q.pop_back());
    m_ra = '0; m_rb = '0; m_sticky = '0;
    @(negedge clk);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_res_data", res_data, 0);
    chk_sticky("midrst_sticky");
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
